// File: rtl/vga_timing_pkg.sv
// Shared constants, offsets and state encoding for the VGA timing detector.
// Defaults describe 640x480 timing with an 800x525 raster.
package vga_timing_pkg;

    localparam int DEF_H_WIDTH      = 10;
    localparam int DEF_V_WIDTH      = 10;
    localparam int DEF_H_SYNC_COUNT = 640;
    localparam int DEF_V_SYNC_COUNT = 480;
    localparam int DEF_LEFT_BORDER  = 47;
    localparam int DEF_TOP_BORDER   = 32;
    localparam int DEF_H_RETRACE    = 96;
    localparam int DEF_V_RETRACE    = 2;
    localparam int DEF_H_MAX        = 799;
    localparam int DEF_V_MAX        = 524;
    localparam int DEF_LOCK_FRAMES  = 2;

    // Distance from the sync leading edge to the first active sample.
    function automatic int sync_offset(input int retrace, input int border);
        return retrace + border;
    endfunction

    localparam int DEF_H_OFF = sync_offset(DEF_H_RETRACE, DEF_LEFT_BORDER);
    localparam int DEF_V_OFF = sync_offset(DEF_V_RETRACE, DEF_TOP_BORDER);

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } state_t;

endpackage

// File: rtl/vga_timing_detector_if.sv
// Sync inputs and recovered timing outputs of the VGA timing detector.
// master: sync source / consumer of coordinates; slave: the detector.
interface vga_timing_detector_if #(
    parameter int h_width = 10,
    parameter int v_width = 10
);

    logic               hsync;
    logic               vsync;
    logic [h_width-1:0] x;
    logic [v_width-1:0] y;
    logic               pixel_valid;
    logic               frame_start;
    logic               locked;
    logic               timing_err;
    logic [h_width-1:0] h_period_m1;
    logic [v_width-1:0] v_period_m1;

    modport master (
        output hsync,
        output vsync,
        input  x,
        input  y,
        input  pixel_valid,
        input  frame_start,
        input  locked,
        input  timing_err,
        input  h_period_m1,
        input  v_period_m1
    );

    modport slave (
        input  hsync,
        input  vsync,
        output x,
        output y,
        output pixel_valid,
        output frame_start,
        output locked,
        output timing_err,
        output h_period_m1,
        output v_period_m1
    );

endinterface

// File: rtl/vga_sync_edge.sv
// Two-stage sampler for one sync pin with polarity normalisation.
// Ports: clk, rst_n, pin (raw sync), start (one-cycle leading-edge pulse).
module vga_sync_edge #(
    parameter bit active_low = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic start
);

    logic s1;
    logic s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= pin ^ active_low;
            s2 <= s1;
        end
    end

    assign start = s1 & ~s2;

endmodule

// File: rtl/vga_timing_detector.sv
// Measures incoming hsync/vsync periods, locks on stable timing and
// regenerates active-area x/y coordinates.
// Ports: clk, rst_n (sync, active low), bus (slave modport: hsync, vsync
// in; x, y, pixel_valid, frame_start, locked, timing_err, h_period_m1,
// v_period_m1 out).
// Optional: define VGA_EXPECT_CHECK_EN to also require h_max/v_max.
module vga_timing_detector
    import vga_timing_pkg::*;
#(
    parameter int h_width         = DEF_H_WIDTH,
    parameter int v_width         = DEF_V_WIDTH,
    parameter int h_sync_count    = DEF_H_SYNC_COUNT,
    parameter int v_sync_count    = DEF_V_SYNC_COUNT,
    parameter int left_border     = DEF_LEFT_BORDER,
    parameter int top_border      = DEF_TOP_BORDER,
    parameter int h_retrace       = DEF_H_RETRACE,
    parameter int v_retrace       = DEF_V_RETRACE,
    parameter int h_max           = DEF_H_MAX,
    parameter int v_max           = DEF_V_MAX,
    parameter int sync_active_low = 1,
    parameter int lock_frames     = DEF_LOCK_FRAMES
) (
    input logic                   clk,
    input logic                   rst_n,
    vga_timing_detector_if.slave  bus
);

    localparam int h_off = sync_offset(h_retrace, left_border);
    localparam int v_off = sync_offset(v_retrace, top_border);

    localparam logic [h_width-1:0] h_lo  = h_width'(h_off);
    localparam logic [h_width-1:0] h_hi  = h_width'(h_off + h_sync_count);
    localparam logic [v_width-1:0] v_lo  = v_width'(v_off);
    localparam logic [v_width-1:0] v_hi  = v_width'(v_off + v_sync_count);
    localparam logic [h_width-1:0] h_all = '1;
    localparam logic [v_width-1:0] v_all = '1;
    localparam logic [h_width-1:0] h_pre = h_all ^ h_width'(1);
    localparam logic [v_width-1:0] v_pre = v_all ^ v_width'(1);
    localparam logic [h_width-1:0] h_one = h_width'(1);
    localparam logic [v_width-1:0] v_one = v_width'(1);
    localparam logic [7:0]         lock_lim = 8'(lock_frames);

`ifdef VGA_EXPECT_CHECK_EN
    localparam logic [h_width-1:0] h_exp = h_width'(h_max);
    localparam logic [v_width-1:0] v_exp = v_width'(v_max);
`endif

    localparam bit pol_low = (sync_active_low != 0);

    logic               hs_start;
    logic               vs_start;
    logic [h_width-1:0] h_cnt;
    logic [v_width-1:0] v_cnt;
    logic               vs_pend;
    logic               frame_bad;
    logic               boundary;
    logic               h_sat;
    logic               v_sat;
    logic               line_bad;
    logic               frame_mis;
    logic               frame_ok;
    logic               h_act;
    logic               v_act;

    state_t             state;
    state_t             state_d;
    logic [7:0]         good_cnt;
    logic [7:0]         good_d;
    logic               err_d;

    vga_sync_edge #(.active_low(pol_low)) u_hs (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (bus.hsync),
        .start (hs_start)
    );

    vga_sync_edge #(.active_low(pol_low)) u_vs (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (bus.vsync),
        .start (vs_start)
    );

    always_comb begin
        // A vsync edge waits for the next hsync edge, which may be
        // in the very same cycle.
        boundary = hs_start & (vs_pend | vs_start);
        // Saturation events fire on the cycle the counter reaches all-ones.
        h_sat    = ~hs_start & (h_cnt == h_pre);
        v_sat    = hs_start & ~boundary & (v_cnt == v_pre);
`ifdef VGA_EXPECT_CHECK_EN
        line_bad  = hs_start & ((h_cnt != bus.h_period_m1) |
                                (h_cnt != h_exp));
        frame_mis = (v_cnt != bus.v_period_m1) | (v_cnt != v_exp);
`else
        line_bad  = hs_start & (h_cnt != bus.h_period_m1);
        frame_mis = (v_cnt != bus.v_period_m1);
`endif
        // The boundary line itself belongs to the frame being judged.
        frame_ok = ~frame_bad & ~line_bad & ~frame_mis;
        h_act    = (h_cnt >= h_lo) & (h_cnt < h_hi);
        v_act    = (v_cnt >= v_lo) & (v_cnt < v_hi);
    end

    always_comb begin
        state_d = state;
        good_d  = good_cnt;
        err_d   = h_sat | v_sat;
        unique case (state)
            SEARCH: begin
                if (boundary) begin
                    state_d = MEASURE;
                    good_d  = '0;
                end
            end
            MEASURE: begin
                if (boundary) begin
                    if (frame_ok) begin
                        good_d = good_cnt + 8'd1;
                        if (good_d >= lock_lim) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (h_sat | v_sat | line_bad | (boundary & frame_mis)) begin
                    err_d   = 1'b1;
                    state_d = MEASURE;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = SEARCH;
                good_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= SEARCH;
            good_cnt <= '0;
        end else begin
            state    <= state_d;
            good_cnt <= good_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt           <= '0;
            v_cnt           <= '0;
            vs_pend         <= 1'b0;
            frame_bad       <= 1'b0;
            bus.h_period_m1 <= '0;
            bus.v_period_m1 <= '0;
            bus.frame_start <= 1'b0;
            bus.timing_err  <= 1'b0;
            bus.locked      <= 1'b0;
            bus.pixel_valid <= 1'b0;
            bus.x           <= '0;
            bus.y           <= '0;
        end else begin
            if (hs_start) begin
                bus.h_period_m1 <= h_cnt;
                h_cnt           <= '0;
            end else if (h_cnt != h_all) begin
                h_cnt <= h_cnt + h_one;
            end

            if (boundary) begin
                bus.v_period_m1 <= v_cnt;
                v_cnt           <= '0;
                vs_pend         <= 1'b0;
                frame_bad       <= 1'b0;
            end else begin
                if (vs_start) begin
                    vs_pend <= 1'b1;
                end
                if (hs_start && v_cnt != v_all) begin
                    v_cnt <= v_cnt + v_one;
                end
                if (line_bad | h_sat | v_sat) begin
                    frame_bad <= 1'b1;
                end
            end

            bus.frame_start <= boundary;
            bus.timing_err  <= err_d;
            bus.locked      <= (state == LOCKED);
            bus.pixel_valid <= h_act & v_act & (state == LOCKED);
            bus.x           <= (h_act & v_act) ? h_cnt - h_lo : '0;
            bus.y           <= (h_act & v_act) ? v_cnt - v_lo : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_detector.sv
// Directed bench for vga_timing_detector on a reduced 40x20 raster
// (4 px hsync, 3 px border, 24 active; 2 line vsync, 3 border, 10 active).
module tb_vga_timing_detector;

    localparam int HW    = 10;
    localparam int VW    = 10;
    localparam int H_TOT = 40;
    localparam int H_RET = 4;
    localparam int H_LB  = 3;
    localparam int H_ACT = 24;
    localparam int V_TOT = 20;
    localparam int V_RET = 2;
    localparam int V_TB  = 3;
    localparam int V_ACT = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int   checks   = 0;
    int   errors   = 0;
    int   fs_seen  = 0;
    int   err_seen = 0;
    int   rise_fs  = 0;
    logic rise_fsq = 1'b0;
    logic lk_q     = 1'b0;
    logic fs_q     = 1'b0;

    vga_timing_detector_if #(.h_width(HW), .v_width(VW)) bus ();

    vga_timing_detector #(
        .h_width        (HW),
        .v_width        (VW),
        .h_sync_count   (H_ACT),
        .v_sync_count   (V_ACT),
        .left_border    (H_LB),
        .top_border     (V_TB),
        .h_retrace      (H_RET),
        .v_retrace      (V_RET),
        .h_max          (H_TOT - 1),
        .v_max          (V_TOT - 1),
        .sync_active_low(1),
        .lock_frames    (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock, then record frame/lock/error events.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.frame_start === 1'b1) fs_seen++;
        if (bus.timing_err === 1'b1) err_seen++;
        if (bus.locked === 1'b1 && lk_q !== 1'b1) begin
            rise_fs  = fs_seen;
            rise_fsq = fs_q;
        end
        lk_q = bus.locked;
        fs_q = bus.frame_start;
    endtask

    task automatic pix(input int l, input int j,
                       input bit vs_early, input int n_lines);
        bus.hsync = (j < H_RET) ? 1'b0 : 1'b1;
        bus.vsync = (l < V_RET ||
                     (vs_early && l == n_lines - 1 && j >= 20)) ? 1'b0 : 1'b1;
        tick();
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_x"}, bus.x, 0);
        check({tag, "_y"}, bus.y, 0);
        check({tag, "_pv"}, bus.pixel_valid, 0);
        check({tag, "_fs"}, bus.frame_start, 0);
        check({tag, "_lk"}, bus.locked, 0);
        check({tag, "_te"}, bus.timing_err, 0);
        check({tag, "_hp"}, bus.h_period_m1, 0);
        check({tag, "_vp"}, bus.v_period_m1, 0);
    endtask

    task automatic run_frame(input int n_lines, input int long_line,
                             input bit vs_early, input int rst_line,
                             input int stop_line, input bit chk_xy);
        for (int l = 0; l < n_lines; l++) begin
            int len;
            if (l == stop_line) return;
            len = (l == long_line) ? H_TOT + 1 : H_TOT;
            for (int j = 0; j < len; j++) begin
                if (l == rst_line && j == 20) begin
                    check("pre_rst_lk", bus.locked, 1);
                    check("pre_rst_vp", bus.v_period_m1, V_TOT - 1);
                    check("pre_rst_err", err_seen, 0);
                    rst_n = 1'b0;
                end
                pix(l, j, vs_early, n_lines);
                if (l == rst_line && j == 20) begin
                    chk_zero("midrst");
                    rst_n    = 1'b1;
                    fs_seen  = 0;
                    rise_fs  = 0;
                    err_seen = 0;
                end
                if (chk_xy) begin
                    if (l == 4 && j == 9) check("pv_l4", bus.pixel_valid, 0);
                    if (l == 5 && j == 8) check("pv_h6", bus.pixel_valid, 0);
                    if (l == 5 && j == 9) begin
                        check("x_first", bus.x, 0);
                        check("y_first", bus.y, 0);
                        check("pv_first", bus.pixel_valid, 1);
                    end
                    if (l == 5 && j == 32) begin
                        check("x_last", bus.x, H_ACT - 1);
                        check("pv_last", bus.pixel_valid, 1);
                    end
                    if (l == 5 && j == 33) begin
                        check("pv_after", bus.pixel_valid, 0);
                        check("x_after", bus.x, 0);
                    end
                    if (l == 14 && j == 9) begin
                        check("y_last", bus.y, V_ACT - 1);
                        check("pv_ylast", bus.pixel_valid, 1);
                    end
                    if (l == 15 && j == 9) check("pv_l15", bus.pixel_valid, 0);
                end
                if (long_line >= 0 && l == long_line + 1) begin
                    if (j == 1) begin
                        check("long_te", bus.timing_err, 1);
                        check("long_lk_hold", bus.locked, 1);
                        check("long_hp", bus.h_period_m1, H_TOT);
                    end
                    if (j == 2) begin
                        check("long_te_off", bus.timing_err, 0);
                        check("long_lk_drop", bus.locked, 0);
                    end
                end
            end
        end
    endtask

    initial begin
        bus.hsync = 1'b1;
        bus.vsync = 1'b1;
        rst_n     = 1'b0;
        repeat (3) tick();
        chk_zero("rst");
        rst_n = 1'b1;
        repeat (5) tick();

        // Frames 1-3: not yet locked.
        repeat (3) run_frame(V_TOT, -1, 1'b0, -1, -1, 1'b0);
        check("hp_clean", bus.h_period_m1, H_TOT - 1);
        check("vp_clean", bus.v_period_m1, V_TOT - 1);
        check("lk_f3", bus.locked, 0);

        // Frame 4: locked from its boundary, coordinate checks.
        run_frame(V_TOT, -1, 1'b0, -1, -1, 1'b1);
        check("rise_fs", rise_fs, 4);
        check("rise_after_fs", rise_fsq, 1);
        check("lk_f4", bus.locked, 1);

        // Frame 5 has one 41-pixel line; frames 6-7 are clean.
        err_seen = 0;
        run_frame(V_TOT, 10, 1'b0, -1, -1, 1'b0);
        repeat (2) run_frame(V_TOT, -1, 1'b0, -1, -1, 1'b0);
        check("lk_f7", bus.locked, 0);
        check("err_long", err_seen, 1);

        // Frame 8: vsync leads hsync at its end.
        run_frame(V_TOT, -1, 1'b1, -1, -1, 1'b0);
        check("relock_fs", rise_fs, 8);
        check("lk_f8", bus.locked, 1);

        // Frame 9: reset mid-frame, then lock restarts from SEARCH.
        err_seen = 0;
        run_frame(V_TOT, -1, 1'b0, 10, -1, 1'b0);
        repeat (3) run_frame(V_TOT, -1, 1'b0, -1, -1, 1'b0);
        check("lk_after_rst", bus.locked, 0);
        run_frame(V_TOT, -1, 1'b0, -1, -1, 1'b0);
        check("rst_rise_fs", rise_fs, 4);
        check("rst_lk", bus.locked, 1);

        // Hold hsync deasserted: counter saturates once, lock drops.
        err_seen = 0;
        run_frame(V_TOT, -1, 1'b0, -1, 4, 1'b0);
        bus.hsync = 1'b1;
        bus.vsync = 1'b1;
        repeat (1100) tick();
        check("sat_err", err_seen, 1);
        check("sat_lk", bus.locked, 0);
        for (int j = 0; j < H_TOT; j++) pix(V_RET + 5, j, 1'b0, V_TOT);
        check("sat_hp", bus.h_period_m1, (1 << HW) - 1);

`ifdef VGA_EXPECT_CHECK_EN
        // Stable but off-nominal 21-line frames never lock.
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        rise_fs = 0;
        repeat (5) run_frame(V_TOT + 1, -1, 1'b0, -1, -1, 1'b0);
        check("exp_lk", bus.locked, 0);
        check("exp_rise", rise_fs, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
